rom_player: RTL and testbench
=============================

# rom_player

Sequencer that sits directly upstream of the pattern `rom` and turns its free-running, address-indexed stream into a proper backpressured AXI4-Stream master. It drives the ROM `addr` and absorbs the ROM's 1-cycle read latency in a small FIFO. It replays an address window once or in a loop, drops ROM entries whose `tvalid` bit is 0, and stops only on packet boundaries. Sits between control/CSR logic and the datapath under test.

## Interface
- AXIS_DATA_WIDTH, 512, tdata width (must match rom)
- AXIS_TUSER_WIDTH, 256, tuser width (must match rom)
- ADDR_WIDTH, 12, rom address width
- FIFO_DEPTH, 3, return-buffer entries (fixed at 3; not user-tunable)

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins replay (ignored while busy)
- stop  in  1  1-cycle pulse; request halt at next packet boundary
- loop_en  in  1  sampled at start; 1 = wrap end→start forever
- start_addr  in  ADDR_WIDTH  first entry, sampled at start
- end_addr  in  ADDR_WIDTH  last entry inclusive, sampled at start
- busy  out  1  high from start acceptance until done
- done  out  1  1-cycle pulse when replay fully drained
- beat_count  out  32  beats accepted downstream since last start
- addr  out  ADDR_WIDTH  to rom addr
- rom_tdata/tkeep/tuser/tvalid/tlast  in  widths per rom  rom outputs
- m_axis_tdata/tkeep/tuser  out  per params  stream payload
- m_axis_tvalid, m_axis_tlast  out  1  stream control
- m_axis_tready  in  1  downstream ready

## Operation
- FSM states IDLE, RUN, DRAIN.
- IDLE: start → latch start_addr/end_addr/loop_en, addr ← start_addr, clear beat_count and stop_pending, go RUN.
- RUN, issue rule: an entry is issued (addr presented, inflight set) when occ + inflight < 3. Both terms are registered; there is no combinational m_axis_tready→addr path.
- After each issue, addr increments modulo 2^ADDR_WIDTH, so start_addr > end_addr wraps through 0. start_addr == end_addr means a one-entry window.
- Issuing end_addr: if loop_en, next addr = start_addr and stay in RUN; else go DRAIN.
- Return path: one cycle after issue the rom_* word is written to the FIFO only if rom_tvalid=1. Invalid entries are consumed silently.
- stop in RUN sets stop_pending:
  - If in_pkt=0, go DRAIN immediately. in_pkt tracks whether the last written return beat lacked tlast; it is 0 after start.
  - Otherwise, the first returned beat with rom_tvalid & rom_tlast stops issuing and goes DRAIN. The single entry possibly already in flight behind it is discarded (discard flag).
- DRAIN: no issue. When FIFO is empty and inflight=0, pulse done and go IDLE.
- stop in IDLE/DRAIN: ignored. start while busy: ignored.
- FIFO head drives m_axis_*. Pop on m_axis_tvalid & m_axis_tready. Payload is held stable while tvalid & !tready.
- beat_count increments per pop and saturates at 2^32-1.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tlast 0, m_axis data/keep/user 0, addr 0, busy 0, done 0, beat_count 0.
- Reset clears the FIFO, inflight, discard and stop_pending, and forces IDLE. This applies mid-replay too; any partial packet is abandoned.
- Latency: start at cycle T → first addr at T+1 → ROM data at T+2 → m_axis_tvalid at T+3, provided the first entry is valid.
- Throughput: 1 beat/clk with tready held high.
- tready low: at most 3 entries are outstanding (FIFO plus in-flight), and the FIFO never overflows.
- busy rises the cycle after start and falls with done.
- done asserts the cycle after the last pop with FIFO empty.

## Structure
- Package rom_player_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - FIFO_DEPTH = 3
  - BEAT_CNT_W = 32
- Sub-module rom_player_fifo: 3-entry synchronous FIFO carrying the {tdata, tkeep, tuser, tlast} word, with occ count, full/empty, and sync reset.
- Top level holds the FSM, address counter, inflight/discard flags and beat counter.

## Test plan
- Single window: ROM 0..3 valid, tlast at 3; start_addr=0, end_addr=3, tready=1 → beats 0..3 on cycles T+3..T+6, tlast on the 4th beat, done at T+7, beat_count=4.
- Bubbles: entries 1 and 2 have tvalid=0 → only 2 beats out, beat_count=2, no gap-induced tvalid glitch.
- Backpressure: tready toggled 1010… over 8 entries → all 8 beats delivered in order, payload stable while stalled, addr never more than 3 ahead of the last popped entry.
- Loop + stop: start=0, end=7, loop_en=1, packets of 4; stop mid-packet on the 2nd pass → output ends exactly at a tlast, no partial packet, done pulses, no beat from the entry after tlast.
- Wrap: start_addr=4094, end_addr=1 with ADDR_WIDTH=12 → addr sequence 4094, 4095, 0, 1; 4 beats.
- Reset mid-replay: assert reset with a stalled beat pending → next cycle m_axis_tvalid=0, busy=0, addr=0; a subsequent start replays cleanly.

Source files
------------

// File: rtl/rom_player_pkg.sv
// Shared types and constants for the rom_player replay sequencer.
package rom_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 3;
  localparam int BEAT_CNT_W = 32;

  // Wrap a return-buffer pointer at FIFO_DEPTH rather than at a power of two.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rom_player_fifo.sv
// Three-entry synchronous return buffer holding packed {tdata, tkeep, tuser, tlast} words.
module rom_player_fifo
  import rom_player_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic [1:0]   occ,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0]   wp;
  logic [1:0]   rp;
  logic         push;
  logic         pull;

  assign full    = (occ == 2'(FIFO_DEPTH));
  assign empty   = (occ == 2'd0);
  assign push    = wr & ~full;
  assign pull    = rd & ~empty;
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= 2'd0;
      rp  <= 2'd0;
      occ <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wr_data;
        wp      <= ptr_inc(wp);
      end
      if (pull) rp <= ptr_inc(rp);
      occ <= occ + {1'b0, push} - {1'b0, pull};
    end
  end

endmodule

// File: rtl/rom_player.sv
// Replay sequencer for the pattern rom: walks an address window once or in a loop,
// absorbs the rom read latency and presents valid entries as a backpressured stream.
module rom_player
  import rom_player_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int ADDR_WIDTH       = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           loop_en,
  input  logic [ADDR_WIDTH-1:0]          start_addr,
  input  logic [ADDR_WIDTH-1:0]          end_addr,
  output logic                           busy,
  output logic                           done,
  output logic [BEAT_CNT_W-1:0]          beat_count,
  output logic [ADDR_WIDTH-1:0]          addr,
  input  logic [AXIS_DATA_WIDTH-1:0]     rom_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]   rom_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]    rom_tuser,
  input  logic                           rom_tvalid,
  input  logic                           rom_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output state_t                         fsm_state
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam int WORD_W = AXIS_DATA_WIDTH + KEEP_W + AXIS_TUSER_WIDTH + 1;

  // Stream handshake: a beat transfers on every clk edge with m_axis_tvalid && m_axis_tready;
  // once tvalid is raised, tvalid and the payload hold until that transfer occurs.

  state_t                state;
  state_t                state_n;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic                  loop_q;
  logic                  inflight;
  logic                  discard;
  logic                  stop_pending;
  logic                  in_pkt;
  logic                  stop_eff;
  logic                  at_end;
  logic                  ret_ok;
  logic                  drop_now;
  logic                  wr;
  logic                  halt;
  logic                  issue;
  logic                  pop;
  logic [1:0]            occ;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WORD_W-1:0]     head;

  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = ~fifo_empty;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = head;
  assign busy          = (state != IDLE);
  assign fsm_state     = state;

  // Issue is gated only by registered occupancy, never by m_axis_tready.
  always_comb begin
    stop_eff = stop | stop_pending;
    at_end   = (addr == end_q);
    ret_ok   = inflight & rom_tvalid & ~discard;
    drop_now = (state == RUN) & stop_eff & ~in_pkt & ~rom_tlast;
    wr       = ret_ok & ~drop_now;
    halt     = (state == RUN) & stop_eff & (~in_pkt | (ret_ok & rom_tlast));
    issue    = (state == RUN) & (({1'b0, occ} + {2'b00, inflight}) < 3'(FIFO_DEPTH));
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (halt || (issue && at_end && !loop_q)) state_n = DRAIN;
      DRAIN: begin
        if (fifo_empty && !inflight) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      start_q      <= '0;
      end_q        <= '0;
      loop_q       <= 1'b0;
      inflight     <= 1'b0;
      discard      <= 1'b0;
      stop_pending <= 1'b0;
      in_pkt       <= 1'b0;
      beat_count   <= '0;
    end else begin
      state    <= state_n;
      inflight <= issue;
      // An entry issued on the cycle we halt belongs to the next packet; drop its return.
      discard  <= halt & issue;
      if (state == IDLE && start) begin
        start_q      <= start_addr;
        end_q        <= end_addr;
        loop_q       <= loop_en;
        addr         <= start_addr;
        beat_count   <= '0;
        stop_pending <= 1'b0;
        in_pkt       <= 1'b0;
      end else begin
        if (issue) addr <= (at_end && loop_q) ? start_q : addr + 1'b1;
        if (state == RUN && stop) stop_pending <= 1'b1;
        if (wr) in_pkt <= ~rom_tlast;
        if (pop && beat_count != '1) beat_count <= beat_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(wr && fifo_full));
  end

  rom_player_fifo #(
    .W(WORD_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .wr_data({rom_tdata, rom_tkeep, rom_tuser, rom_tlast}),
    .rd     (pop),
    .rd_data(head),
    .occ    (occ),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_rom_player.sv
// Scoreboard bench for rom_player: a rom model with 1-cycle latency, window-walk reference model,
// and a monitor that pops expected beats on every accepted transfer.
module tb_rom_player;
  import rom_player_pkg::*;

  localparam int DW    = 32;
  localparam int UW    = 8;
  localparam int KW    = DW / 8;
  localparam int AW    = 12;
  localparam int W     = DW + KW + UW + 1;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          busy;
  logic          done;
  logic [31:0]   beat_count;
  logic [AW-1:0] addr;
  logic [DW-1:0] rom_tdata = '0;
  logic [KW-1:0] rom_tkeep = '0;
  logic [UW-1:0] rom_tuser = '0;
  logic          rom_tvalid = 1'b0;
  logic          rom_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  state_t        fsm_state;

  rom_player #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_TUSER_WIDTH(UW),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .busy         (busy),
    .done         (done),
    .beat_count   (beat_count),
    .addr         (addr),
    .rom_tdata    (rom_tdata),
    .rom_tkeep    (rom_tkeep),
    .rom_tuser    (rom_tuser),
    .rom_tvalid   (rom_tvalid),
    .rom_tlast    (rom_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .fsm_state    (fsm_state)
  );

  // ---------------- rom model (1-cycle read latency) ----------------
  logic [DW-1:0] m_data  [DEPTH];
  logic [KW-1:0] m_keep  [DEPTH];
  logic [UW-1:0] m_user  [DEPTH];
  logic          m_valid [DEPTH];
  logic          m_last  [DEPTH];

  always @(posedge clk) begin
    rom_tdata  <= m_data[addr];
    rom_tkeep  <= m_keep[addr];
    rom_tuser  <= m_user[addr];
    rom_tvalid <= m_valid[addr];
    rom_tlast  <= m_last[addr];
  end

  task automatic set_entry(input int a, input bit v, input bit l);
    m_data[a]  = $urandom;
    m_keep[a]  = KW'($urandom);
    m_user[a]  = UW'($urandom);
    m_valid[a] = v;
    m_last[a]  = l;
  endtask

  // ---------------- downstream ready driver ----------------
  int rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 held low
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        2:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_pass = 0;
  logic [W-1:0]  exp_q[$];
  int            beats_seen = 0;
  bit            done_seen = 0;
  int            first_beat_cyc = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  bit            last_tlast = 0;
  bit            stall_prev = 0;
  logic [W-1:0]  prev_word = '0;
  logic [W-1:0]  cur_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    cur_word = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_payload", 64'(cur_word), 64'(prev_word));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", cur_word);
        end else begin
          check("beat", 64'(cur_word), 64'(exp_q.pop_front()));
        end
        if (beats_seen == 0) first_beat_cyc = cycle;
        beats_seen++;
        last_tlast = m_axis_tlast;
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cycle;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_word  = cur_word;
    end
  end

  // ---------------- reference model: walk the window, keep valid entries ----------------
  task automatic expect_window(input int s, input int e, output int nvalid);
    int a;
    a = s;
    nvalid = 0;
    forever begin
      if (m_valid[a]) begin
        exp_q.push_back({m_data[a], m_keep[a], m_user[a], m_last[a]});
        nvalid++;
      end
      if (a == e) break;
      a = (a + 1) % DEPTH;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_replay(input int s, input int e, input bit lp);
    beats_seen = 0;
    done_seen  = 1'b0;
    @(posedge clk);
    #1;
    start_addr = AW'(s);
    end_addr   = AW'(e);
    loop_en    = lp;
    start      = 1'b1;
    start_cyc  = cycle;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_seen) begin
      n_checks++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", budget);
    end
  endtask

  task automatic finish_window(input string tag, input int nexp);
    wait_done(400);
    check({tag, "_beat_count"}, 64'(beat_count), 64'(nexp));
    check({tag, "_beats_seen"}, 64'(beats_seen), 64'(nexp));
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int p;
    int s;
    int e;
    int len;
    for (int i = 0; i < DEPTH; i++) set_entry(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_beat_count", 64'(beat_count), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(IDLE));
    @(posedge clk);
    #1 reset = 1'b0;

    // single window with latency checks
    for (int i = 0; i < 4; i++) set_entry(i, 1'b1, i == 3);
    expect_window(0, 3, n);
    start_replay(0, 3, 1'b0);
    @(negedge clk);
    check("single_first_addr", 64'(addr), 64'd0);
    check("single_busy", 64'(busy), 64'd1);
    finish_window("single", n);
    check("single_first_latency", 64'(first_beat_cyc - start_cyc), 64'd3);
    check("single_done_latency", 64'(done_cyc - start_cyc), 64'd7);
    check("single_last_tlast", 64'(last_tlast), 64'd1);

    // bubbles
    set_entry(16, 1'b1, 1'b0);
    set_entry(17, 1'b0, 1'b0);
    set_entry(18, 1'b0, 1'b0);
    set_entry(19, 1'b1, 1'b1);
    expect_window(16, 19, n);
    start_replay(16, 19, 1'b0);
    finish_window("bubbles", n);

    // backpressure 1010...
    for (int i = 32; i < 40; i++) set_entry(i, 1'b1, (i % 4) == 3);
    rdy_mode = 1;
    expect_window(32, 39, n);
    start_replay(32, 39, 1'b0);
    finish_window("backpressure", n);
    rdy_mode = 0;

    // address wrap through 0
    set_entry(4094, 1'b1, 1'b0);
    set_entry(4095, 1'b1, 1'b0);
    set_entry(0, 1'b1, 1'b0);
    set_entry(1, 1'b1, 1'b1);
    expect_window(4094, 1, n);
    start_replay(4094, 1, 1'b0);
    finish_window("wrap", n);

    // loop + stop mid-packet on the second pass
    for (int i = 64; i < 72; i++) set_entry(i, 1'b1, (i % 4) == 3);
    for (int k = 0; k < 10; k++) expect_window(64, 71, n);
    start_replay(64, 71, 1'b1);
    n = 0;
    while (beats_seen < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("loop_reached_pass2", 64'(beats_seen >= 10), 64'd1);
    @(posedge clk);
    #1 stop = 1'b1;
    p = beats_seen;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_done(200);
    check("loop_ends_on_tlast", 64'(last_tlast), 64'd1);
    check("loop_whole_packets", 64'(beats_seen % 4), 64'd0);
    check("loop_stop_window", 64'(beats_seen >= p && beats_seen <= p + 8), 64'd1);
    check("loop_beat_count", 64'(beat_count), 64'(beats_seen));
    exp_q.delete();
    @(negedge clk);
    check("loop_busy_after_done", 64'(busy), 64'd0);

    // reset with a stalled beat pending
    set_entry(100, 1'b1, 1'b0);
    rdy_mode = 3;
    expect_window(100, 105, n);
    start_replay(100, 105, 1'b0);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_stalled_beat", 64'(m_axis_tvalid), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_addr", 64'(addr), 64'd0);
    exp_q.delete();
    reset = 1'b0;
    rdy_mode = 2;
    expect_window(100, 105, n);
    start_replay(100, 105, 1'b0);
    finish_window("rstmid_replay", n);

    // random windows, random ready; first one is a one-entry window
    for (int k = 0; k < 6; k++) begin
      s   = $urandom_range(0, DEPTH - 1);
      len = (k == 0) ? 1 : $urandom_range(2, 12);
      e   = (s + len - 1) % DEPTH;
      expect_window(s, e, n);
      start_replay(s, e, 1'b0);
      finish_window("random", n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 time units, expected summary earlier");
    $fatal(1);
  end

endmodule
